// File: rtl/score_display.sv
// Score capture and 8-digit multiplexed seven-segment driver.
// Define SCORE_DISP_BCD_EN to convert the binary score to decimal before display.
module score_display #(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] val_in,
  input  logic        load,
  output logic [6:0]  cat_out,
  output logic [7:0]  an_out,
  output logic        busy
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       dig_idx;
  logic [31:0]      disp_reg;
  logic [3:0]       nibble;
  logic [6:0]       glyph;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dig_idx <= dig_idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    nibble = disp_reg[{dig_idx, 2'b00} +: 4];
    glyph  = 7'h7F;
    case (nibble)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end

  // Anode and segments registered together so one digit is lit at a time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_out  <= 8'hFF;
      cat_out <= 7'h7F;
    end else begin
      an_out  <= ~(8'b1 << dig_idx);
      cat_out <= glyph;
    end
  end

`ifdef SCORE_DISP_BCD_EN
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state;
  logic [31:0] bin_sr;
  logic [31:0] pend_reg;
  logic [39:0] bcd;
  logic [39:0] bcd_adj;
  logic [4:0]  bit_cnt;
  logic        pending;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bin_sr   <= '0;
      pend_reg <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      pending  <= 1'b0;
      disp_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            bin_sr  <= val_in;
            bcd     <= '0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd, bin_sr} <= {bcd_adj[38:0], bin_sr, 1'b0};
          bit_cnt       <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) state <= ST_DONE;
          if (load) begin
            pend_reg <= val_in;
            pending  <= 1'b1;
          end
        end
        ST_DONE: begin
          disp_reg <= (bcd[39:32] != 8'd0) ? 32'h9999_9999 : bcd[31:0];
          // A load arriving now supersedes any older pending word and restarts directly.
          if (load || pending) begin
            bin_sr  <= load ? val_in : pend_reg;
            bcd     <= '0;
            bit_cnt <= '0;
            pending <= 1'b0;
            state   <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     disp_reg <= '0;
    else if (load) disp_reg <= val_in;
  end

  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: scan sequence, glyphs, load timing, BCD conversion and async reset.
module tb_score_display;
  localparam int unsigned SCAN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] val_in;
  logic [6:0]  cat_out;
  logic [7:0]  an_out;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int seen42 = 0;
  int busy_low = 0;

  score_display #(.SCAN_DIV(SCAN)) dut (
    .clk(clk), .reset(reset), .val_in(val_in), .load(load),
    .cat_out(cat_out), .an_out(an_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic [31:0] disp_hex;
    logic [31:0] disp_bcd;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [6:0] seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (dut.disp_reg == 32'h42) seen42++;
      if (!busy) busy_low++;
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    @(negedge clk);
    val_in = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic scan_check(input logic [31:0] exp);
    int w;
    logic [7:0] m;
    w = 0;
    while (an_out !== 8'hFE && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) check("scan_sync", {24'd0, an_out}, 32'hFE);
    for (int d = 0; d < 8; d++) begin
      m = 8'b1 << d;
      check($sformatf("an_dig%0d", d), {24'd0, an_out}, {24'd0, ~m});
      check($sformatf("cat_dig%0d", d), {25'd0, cat_out}, {25'd0, seg(exp[4*d +: 4])});
      repeat (SCAN) @(negedge clk);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] exp);
    int idx;
    logic [7:0] m;
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      m = 8'b1 << i;
      if (an_out == ~m) idx = i;
    end
    if (idx < 0) check({name, "_an"}, {24'd0, an_out}, 32'hFE);
    else check(name, {25'd0, cat_out}, {25'd0, seg(exp[4*idx +: 4])});
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp;
    logic [7:0]  m;
    int cnt;

    vecs[0] = '{32'h1234_ABCD, 32'h1234_ABCD, 32'h9999_9999};
    vecs[1] = '{32'h89EF_5670, 32'h89EF_5670, 32'h9999_9999};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h9999_9999};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'h00BC_614E, 32'h00BC_614E, 32'h1234_5678};
    vecs[5] = '{32'h05F5_E100, 32'h05F5_E100, 32'h9999_9999};
    vecs[6] = '{32'h05F5_E0FF, 32'h05F5_E0FF, 32'h9999_9999};
    vecs[7] = '{32'h0000_002A, 32'h0000_002A, 32'h0000_0042};

    reset  = 1'b1;
    load   = 1'b0;
    val_in = '0;
    repeat (5) @(negedge clk);
    check("rst_an", {24'd0, an_out}, 32'hFF);
    check("rst_cat", {25'd0, cat_out}, 32'h7F);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      m = 8'b1 << (k / SCAN);
      check($sformatf("boot_an%0d", k), {24'd0, an_out}, {24'd0, ~m});
      check($sformatf("boot_cat%0d", k), {25'd0, cat_out}, 32'h40);
    end

    for (int v = 0; v < 8; v++) begin
`ifdef SCORE_DISP_BCD_EN
      exp = vecs[v].disp_bcd;
      do_load(vecs[v].val);
      cnt = 0;
      while (busy && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      check($sformatf("busy_len_v%0d", v), cnt, 33);
`else
      exp = vecs[v].disp_hex;
      do_load(vecs[v].val);
      check($sformatf("busy_v%0d", v), {31'd0, busy}, 32'd0);
`endif
      check($sformatf("disp_v%0d", v), dut.disp_reg, exp);
      @(negedge clk);
      scan_check(exp);
    end

`ifdef SCORE_DISP_BCD_EN
    seen42 = 0;
    busy_low = 0;
    do_load(32'd5);
    step(9);
    val_in = 32'd42; load = 1'b1;
    step(1);
    load = 1'b0;
    step(9);
    val_in = 32'd7; load = 1'b1;
    step(1);
    load = 1'b0;
    step(13);
    check("pend_first", dut.disp_reg, 32'h5);
    step(32);
    check("pend_busy_gap", busy_low, 0);
    step(2);
    check("pend_second", dut.disp_reg, 32'h7);
    check("pend_busy_end", {31'd0, busy}, 32'd0);
    check("pend_no42", seen42, 0);
`else
    @(negedge clk);
    val_in = 32'h0000_0001; load = 1'b1;
    @(negedge clk);
    val_in = 32'hCAFE_F00D;
    @(negedge clk);
    load = 1'b0;
    check("b2b_last", dut.disp_reg, 32'hCAFE_F00D);
    @(negedge clk);
    check_lit("b2b_lit", 32'hCAFE_F00D);
`endif

    do_load(32'd12_345_678);
    step(14);
    #2 reset = 1'b1;
    #1;
    check("arst_an", {24'd0, an_out}, 32'hFF);
    check("arst_cat", {25'd0, cat_out}, 32'h7F);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_disp", dut.disp_reg, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(40);
    check("arst_after_disp", dut.disp_reg, 32'd0);
    check("arst_after_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
